kat_adc_iic_byte_engine: RTL and testbench

//  Bit-level IIC master for the KAT ADC control path. Sits directly below kat_adc_iic_controller:

---
 rtl/kat_adc_iic_byte_engine.sv | 220 ++++++++++++++++++++++
 tb/tb_kat_adc_iic_byte_engine.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/kat_adc_iic_byte_engine.sv
`default_nettype none
// ============================================================================
// Module      : kat_adc_iic_byte_engine
// Description : Bit-level IIC master. Takes one op word per byte and produces
//               an optional (repeated) START, nine bit slots and an optional
//               STOP on open-drain SCL/SDA. Returns the sampled byte and the
//               ninth-bit ack level. Honours slave clock stretching.
// Revision    : 1.0 - initial release
// ============================================================================
module kat_adc_iic_byte_engine #(
    parameter int CORE_FREQ = 100,
    parameter int IIC_FREQ  = 1
) (
    input  logic       OPB_Clk,
    input  logic       OPB_Rst,
    input  logic       op_valid,
    output logic       op_ready,
    input  logic       op_start,
    input  logic       op_stop,
    input  logic       op_rnw,
    input  logic       op_nack,
    input  logic [7:0] op_data,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic       rd_ack,
    output logic       busy,
    input  logic       sda_i,
    input  logic       scl_i,
    output logic       sda_o,
    output logic       scl_o,
    output logic       sda_t,
    output logic       scl_t
);

    // Quarter-bit length in clocks, never below one clock.
    localparam int c_quarter_raw = CORE_FREQ / (4 * IIC_FREQ);
    localparam int c_quarter     = (c_quarter_raw < 1) ? 1 : c_quarter_raw;
    localparam int c_cnt_w       = (c_quarter > 1) ? $clog2(c_quarter) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(c_quarter - 1);

    localparam logic [1:0] c_s_idle  = 2'd0;
    localparam logic [1:0] c_s_start = 2'd1;
    localparam logic [1:0] c_s_bit   = 2'd2;
    localparam logic [1:0] c_s_stop  = 2'd3;

    logic [1:0]         r_state;
    logic [3:0]         r_bit;
    logic [1:0]         r_qtr;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_scl_seen;
    logic               r_held;
    logic               r_stop;
    logic               r_rnw;
    logic               r_nack;
    logic [7:0]         r_data;
    logic [7:0]         r_shift;
    logic               r_ack;
    logic               r_sda_t;
    logic               r_scl_t;
    logic               r_op_ready;
    logic               r_busy;
    logic               r_rd_valid;
    logic [7:0]         r_rd_data;
    logic               r_rd_ack;

    logic [3:0]         w_nbit;
    logic               w_nsda;
    logic               w_first_sda;
    logic               w_tick;

    assign sda_o    = 1'b0;
    assign scl_o    = 1'b0;
    assign sda_t    = r_sda_t;
    assign scl_t    = r_scl_t;
    assign op_ready = r_op_ready;
    assign busy     = r_busy;
    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_data;
    assign rd_ack   = r_rd_ack;

    // SDA level for the bit slot about to start (next bit, or first bit of a new op).
    always_comb begin
        w_nbit      = (r_state == c_s_bit) ? (r_bit + 4'd1) : 4'd0;
        if (w_nbit == 4'd8) begin
            w_nsda = r_rnw ? r_nack : 1'b1;
        end else begin
            w_nsda = r_rnw ? 1'b1 : r_data[3'd7 - w_nbit[2:0]];
        end
        w_first_sda = op_rnw ? 1'b1 : op_data[7];
        // q1 only counts once SCL has actually been seen high (clock stretching).
        w_tick      = (r_qtr != 2'd1) || scl_i || r_scl_seen;
    end

    // Sequencer: accepts ops, walks quarters through START/BIT/STOP, drives the lines.
    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            r_state    <= c_s_idle;
            r_bit      <= 4'd0;
            r_qtr      <= 2'd0;
            r_cnt      <= '0;
            r_scl_seen <= 1'b0;
            r_held     <= 1'b0;
            r_stop     <= 1'b0;
            r_rnw      <= 1'b0;
            r_nack     <= 1'b0;
            r_data     <= 8'd0;
            r_shift    <= 8'd0;
            r_ack      <= 1'b0;
            r_sda_t    <= 1'b1;
            r_scl_t    <= 1'b1;
            r_op_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= 8'd0;
            r_rd_ack   <= 1'b0;
        end else begin
            r_rd_valid <= 1'b0;
            if (r_state == c_s_idle) begin
                if (op_valid && r_op_ready) begin
                    r_stop     <= op_stop;
                    r_rnw      <= op_rnw;
                    r_nack     <= op_nack;
                    r_data     <= op_data;
                    r_op_ready <= 1'b0;
                    r_busy     <= 1'b1;
                    r_qtr      <= 2'd0;
                    r_cnt      <= '0;
                    r_scl_seen <= 1'b0;
                    // A free bus always needs a START, whatever the op asked for.
                    if (op_start || !r_held) begin
                        r_state <= c_s_start;
                        r_sda_t <= 1'b1;
                    end else begin
                        r_state <= c_s_bit;
                        r_bit   <= 4'd0;
                        r_sda_t <= w_first_sda;
                    end
                end else begin
                    r_op_ready <= 1'b1;
                end
            end else begin
                if ((r_qtr == 2'd1) && scl_i) begin
                    r_scl_seen <= 1'b1;
                end
                if ((r_state == c_s_bit) && (r_qtr == 2'd2) && (r_cnt == '0)) begin
                    if (r_bit == 4'd8) begin
                        r_ack <= sda_i;
                    end else begin
                        r_shift[3'd7 - r_bit[2:0]] <= sda_i;
                    end
                end
                if (w_tick) begin
                    if (r_cnt != c_cnt_last) begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end else begin
                        r_cnt      <= '0;
                        r_qtr      <= r_qtr + 2'd1;
                        r_scl_seen <= 1'b0;
                        case (r_state)
                            c_s_start: begin
                                case (r_qtr)
                                    2'd0:    r_scl_t <= 1'b1;
                                    2'd1:    r_sda_t <= 1'b0;
                                    2'd2:    r_scl_t <= 1'b0;
                                    default: begin
                                        r_state <= c_s_bit;
                                        r_bit   <= 4'd0;
                                        r_sda_t <= w_nsda;
                                    end
                                endcase
                            end
                            c_s_bit: begin
                                case (r_qtr)
                                    2'd0:    r_scl_t <= 1'b1;
                                    2'd1:    r_scl_t <= r_scl_t;
                                    2'd2:    r_scl_t <= 1'b0;
                                    default: begin
                                        if (r_bit == 4'd8) begin
                                            r_rd_valid <= 1'b1;
                                            r_rd_data  <= r_shift;
                                            r_rd_ack   <= r_ack;
                                            if (r_stop) begin
                                                r_state <= c_s_stop;
                                                r_sda_t <= 1'b0;
                                            end else begin
                                                // Bus stays owned: SCL low, SDA untouched.
                                                r_state    <= c_s_idle;
                                                r_held     <= 1'b1;
                                                r_busy     <= 1'b1;
                                                r_op_ready <= 1'b1;
                                            end
                                        end else begin
                                            r_bit   <= r_bit + 4'd1;
                                            r_sda_t <= w_nsda;
                                        end
                                    end
                                endcase
                            end
                            default: begin
                                case (r_qtr)
                                    2'd0:    r_scl_t <= 1'b1;
                                    2'd1:    r_sda_t <= 1'b1;
                                    2'd2:    r_scl_t <= 1'b1;
                                    default: begin
                                        r_state    <= c_s_idle;
                                        r_held     <= 1'b0;
                                        r_busy     <= 1'b0;
                                        r_op_ready <= 1'b1;
                                    end
                                endcase
                            end
                        endcase
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_kat_adc_iic_byte_engine.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_kat_adc_iic_byte_engine
// Description : Directed bench for the IIC byte engine with an open-drain
//               bus and a simple slave (ACK, 0xC3 read buffer, stretching).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_kat_adc_iic_byte_engine;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       op_valid = 1'b0, op_start = 1'b0, op_stop = 1'b0;
    logic       op_rnw = 1'b0, op_nack = 1'b0;
    logic [7:0] op_data = 8'd0;
    logic       op_ready, rd_valid, rd_ack, busy;
    logic [7:0] rd_data;
    logic       sda_i, scl_i, sda_o, scl_o, sda_t, scl_t;

    // Slave-side bus pulls and bookkeeping
    logic       sl_sda_low = 1'b0, sl_scl_low = 1'b0;
    logic       sl_rd = 1'b0, sl_present = 1'b1, stretch_en = 1'b0;
    logic       p_scl = 1'b1, p_sda = 1'b1, m_ack = 1'b0, nacked = 1'b0;
    logic       s, d;
    logic [7:0] rx = 8'd0;
    logic [7:0] rdbuf = 8'hC3;
    logic [7:0] blog[$];
    int         n_start = 0, n_stop = 0, n_rdv = 0, bitpos = -2, fall_no = 0, hold = 0;

    int cyc = 0;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign sda_i = (sda_t ? 1'b1 : sda_o) & ~sl_sda_low;
    assign scl_i = (scl_t ? 1'b1 : scl_o) & ~sl_scl_low;

    kat_adc_iic_byte_engine #(.CORE_FREQ(10), .IIC_FREQ(1)) dut (
        .OPB_Clk(clk), .OPB_Rst(rst),
        .op_valid(op_valid), .op_ready(op_ready), .op_start(op_start), .op_stop(op_stop),
        .op_rnw(op_rnw), .op_nack(op_nack), .op_data(op_data),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_ack(rd_ack), .busy(busy),
        .sda_i(sda_i), .scl_i(scl_i), .sda_o(sda_o), .scl_o(scl_o),
        .sda_t(sda_t), .scl_t(scl_t)
    );

    // Slave model: START/STOP detect, bit shift on SCL rise, drive SDA after SCL fall.
    always @(negedge clk) begin
        s = scl_i;
        d = sda_i;
        if (rd_valid) n_rdv++;
        if (hold > 0) begin
            hold--;
            if (hold == 0) sl_scl_low = 1'b0;
        end
        if (p_scl && s && p_sda && !d) begin
            n_start++; bitpos = -1; fall_no = 0; nacked = 1'b0; sl_sda_low = 1'b0;
        end else if (p_scl && s && !p_sda && d) begin
            n_stop++; bitpos = -2; sl_sda_low = 1'b0;
        end else if (!p_scl && s) begin
            if (bitpos >= 0 && bitpos < 8) rx = {rx[6:0], d};
            else if (bitpos == 8) begin
                m_ack = d;
                if (sl_rd && d) nacked = 1'b1;
            end
        end else if (p_scl && !s) begin
            fall_no++;
            if (stretch_en && fall_no == 4) begin
                sl_scl_low = 1'b1;
                hold = 54;
            end
            if (bitpos == -1) bitpos = 0;
            else if (bitpos >= 0) bitpos++;
            if (bitpos == 9) bitpos = 0;
            if (bitpos == 8) begin
                if (!sl_rd) begin
                    blog.push_back(rx);
                    sl_sda_low = sl_present;
                end else begin
                    sl_sda_low = 1'b0;
                end
            end else if (bitpos >= 0) begin
                sl_sda_low = sl_rd && sl_present && !nacked && !rdbuf[3'(7 - bitpos)];
            end
        end
        p_scl = s;
        p_sda = d;
    end

    task automatic issue(input logic st, input logic sp, input logic rnw, input logic nk,
                         input logic [7:0] dat, output int n);
        @(negedge clk);
        op_start = st; op_stop = sp; op_rnw = rnw; op_nack = nk; op_data = dat;
        op_valid = 1'b1;
        for (int i = 0; i < 200 && !op_ready; i++) @(negedge clk);
        if (!op_ready) begin
            total++; bad++;
            $display("FAIL accept_timeout: op_ready=%b required 1", op_ready);
        end
        n = cyc + 1;
        @(negedge clk);
        op_valid = 1'b0;
    endtask

    task automatic wait_done(input int n, output int lat);
        lat = -1;
        for (int i = 0; i < 3000; i++) begin
            if (op_ready) begin
                lat = cyc + 1 - n;
                break;
            end
            @(negedge clk);
        end
        if (lat < 0) begin
            total++; bad++;
            $display("FAIL done_timeout: op_ready never returned");
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (sda_t !== 1'b1) begin bad++; $display("FAIL rst_sda_t: got %b want 1", sda_t); end
        total++; if (scl_t !== 1'b1) begin bad++; $display("FAIL rst_scl_t: got %b want 1", scl_t); end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL rst_rd_valid: got %b want 0", rd_valid); end
        total++; if (rd_data !== 8'h00) begin bad++; $display("FAIL rst_rd_data: got %h want 00", rd_data); end
        total++; if (rd_ack !== 1'b0) begin bad++; $display("FAIL rst_rd_ack: got %b want 0", rd_ack); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        total++; if (op_ready !== 1'b0) begin bad++; $display("FAIL rst_op_ready: got %b want 0", op_ready); end
        rst = 1'b0;
        @(negedge clk);
        total++; if (op_ready !== 1'b1) begin bad++; $display("FAIL rst_ready_after: got %b want 1", op_ready); end
    endtask

    task automatic test_write_ss;
        int n, lat, s0, p0, v0, b0;
        logic [7:0] got;
        s0 = n_start; p0 = n_stop; v0 = n_rdv; b0 = blog.size();
        issue(1'b1, 1'b1, 1'b0, 1'b0, 8'h53, n);
        wait_done(n, lat);
        got = (blog.size() > b0) ? blog[b0] : 8'hxx;
        total++; if (lat != 89) begin bad++; $display("FAIL wr_latency: got %0d want 89", lat); end
        total++; if (n_start - s0 != 1) begin bad++; $display("FAIL wr_starts: got %0d want 1", n_start - s0); end
        total++; if (n_stop - p0 != 1) begin bad++; $display("FAIL wr_stops: got %0d want 1", n_stop - p0); end
        total++; if (got !== 8'h53) begin bad++; $display("FAIL wr_slave_byte: got %h want 53", got); end
        total++; if (rd_ack !== 1'b0) begin bad++; $display("FAIL wr_ack: got %b want 0", rd_ack); end
        total++; if (rd_data !== 8'h53) begin bad++; $display("FAIL wr_readback: got %h want 53", rd_data); end
        total++; if (n_rdv - v0 != 1) begin bad++; $display("FAIL wr_rd_valid_pulses: got %0d want 1", n_rdv - v0); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL wr_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_back_to_back;
        int n, lat, s0, p0, v0, b0;
        logic [7:0] g0, g1;
        s0 = n_start; p0 = n_stop; v0 = n_rdv; b0 = blog.size();
        issue(1'b1, 1'b0, 1'b0, 1'b0, 8'h78, n);
        wait_done(n, lat);
        total++; if (lat != 81) begin bad++; $display("FAIL b2b_lat1: got %0d want 81", lat); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy_held: got %b want 1", busy); end
        total++; if (scl_t !== 1'b0) begin bad++; $display("FAIL b2b_scl_held: got %b want 0", scl_t); end
        issue(1'b0, 1'b1, 1'b0, 1'b0, 8'h0F, n);
        wait_done(n, lat);
        g0 = (blog.size() > b0) ? blog[b0] : 8'hxx;
        g1 = (blog.size() > b0 + 1) ? blog[b0 + 1] : 8'hxx;
        total++; if (lat != 81) begin bad++; $display("FAIL b2b_lat2: got %0d want 81", lat); end
        total++; if (n_start - s0 != 1) begin bad++; $display("FAIL b2b_starts: got %0d want 1", n_start - s0); end
        total++; if (n_stop - p0 != 1) begin bad++; $display("FAIL b2b_stops: got %0d want 1", n_stop - p0); end
        total++; if (g0 !== 8'h78) begin bad++; $display("FAIL b2b_byte0: got %h want 78", g0); end
        total++; if (g1 !== 8'h0F) begin bad++; $display("FAIL b2b_byte1: got %h want 0f", g1); end
        total++; if (n_rdv - v0 != 2) begin bad++; $display("FAIL b2b_pulses: got %0d want 2", n_rdv - v0); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_repeated_start;
        int n, lat, s0, p0, v0, b0;
        logic [7:0] g0;
        s0 = n_start; p0 = n_stop; v0 = n_rdv; b0 = blog.size();
        sl_rd = 1'b0;
        issue(1'b1, 1'b0, 1'b0, 1'b0, 8'h18, n);
        wait_done(n, lat);
        total++; if (lat != 81) begin bad++; $display("FAIL rs_lat1: got %0d want 81", lat); end
        sl_rd = 1'b1;
        issue(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, n);
        wait_done(n, lat);
        sl_rd = 1'b0;
        g0 = (blog.size() > b0) ? blog[b0] : 8'hxx;
        total++; if (lat != 89) begin bad++; $display("FAIL rs_lat2: got %0d want 89", lat); end
        total++; if (n_start - s0 != 2) begin bad++; $display("FAIL rs_starts: got %0d want 2", n_start - s0); end
        total++; if (n_stop - p0 != 1) begin bad++; $display("FAIL rs_stops: got %0d want 1", n_stop - p0); end
        total++; if (g0 !== 8'h18) begin bad++; $display("FAIL rs_wr_byte: got %h want 18", g0); end
        total++; if (rd_data !== 8'hC3) begin bad++; $display("FAIL rs_rd_data: got %h want c3", rd_data); end
        total++; if (rd_ack !== 1'b1) begin bad++; $display("FAIL rs_rd_ack: got %b want 1", rd_ack); end
        total++; if (m_ack !== 1'b1) begin bad++; $display("FAIL rs_master_nack: got %b want 1", m_ack); end
        total++; if (n_rdv - v0 != 2) begin bad++; $display("FAIL rs_pulses: got %0d want 2", n_rdv - v0); end
    endtask

    task automatic test_stretch;
        int n, lat, b0;
        logic [7:0] g0;
        b0 = blog.size();
        stretch_en = 1'b1;
        issue(1'b1, 1'b1, 1'b0, 1'b0, 8'h53, n);
        wait_done(n, lat);
        stretch_en = 1'b0;
        g0 = (blog.size() > b0) ? blog[b0] : 8'hxx;
        total++; if (lat != 139) begin bad++; $display("FAIL st_latency: got %0d want 139", lat); end
        total++; if (g0 !== 8'h53) begin bad++; $display("FAIL st_byte: got %h want 53", g0); end
        total++; if (rd_ack !== 1'b0) begin bad++; $display("FAIL st_ack: got %b want 0", rd_ack); end
    endtask

    task automatic test_no_slave;
        int n, lat, p0, v0;
        p0 = n_stop; v0 = n_rdv;
        sl_present = 1'b0;
        issue(1'b1, 1'b1, 1'b0, 1'b0, 8'hA5, n);
        wait_done(n, lat);
        sl_present = 1'b1;
        total++; if (rd_ack !== 1'b1) begin bad++; $display("FAIL ns_ack: got %b want 1", rd_ack); end
        total++; if (n_rdv - v0 != 1) begin bad++; $display("FAIL ns_pulses: got %0d want 1", n_rdv - v0); end
        total++; if (n_stop - p0 != 1) begin bad++; $display("FAIL ns_stops: got %0d want 1", n_stop - p0); end
        total++; if (rd_data !== 8'hA5) begin bad++; $display("FAIL ns_readback: got %h want a5", rd_data); end
        total++; if (lat != 89) begin bad++; $display("FAIL ns_latency: got %0d want 89", lat); end
    endtask

    task automatic test_reset_mid;
        int n, lat, b0;
        logic [7:0] g0;
        issue(1'b1, 1'b1, 1'b0, 1'b0, 8'h99, n);
        repeat (42) @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rm_busy_before: got %b want 1", busy); end
        rst = 1'b1;
        @(negedge clk);
        total++; if (sda_t !== 1'b1) begin bad++; $display("FAIL rm_sda_t: got %b want 1", sda_t); end
        total++; if (scl_t !== 1'b1) begin bad++; $display("FAIL rm_scl_t: got %b want 1", scl_t); end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL rm_rd_valid: got %b want 0", rd_valid); end
        total++; if (op_ready !== 1'b0) begin bad++; $display("FAIL rm_ready_in_rst: got %b want 0", op_ready); end
        rst = 1'b0;
        @(negedge clk);
        total++; if (op_ready !== 1'b1) begin bad++; $display("FAIL rm_ready_after: got %b want 1", op_ready); end
        b0 = blog.size();
        issue(1'b1, 1'b1, 1'b0, 1'b0, 8'h20, n);
        wait_done(n, lat);
        g0 = (blog.size() > b0) ? blog[b0] : 8'hxx;
        total++; if (lat != 89) begin bad++; $display("FAIL rm_latency: got %0d want 89", lat); end
        total++; if (g0 !== 8'h20) begin bad++; $display("FAIL rm_byte: got %h want 20", g0); end
        total++; if (rd_ack !== 1'b0) begin bad++; $display("FAIL rm_ack: got %b want 0", rd_ack); end
    endtask

    initial begin
        test_reset;
        test_write_ss;
        test_back_to_back;
        test_repeated_start;
        test_stretch;
        test_no_slave;
        test_reset_mid;
        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
